// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// sram_bus_arbiter : two-master (inst/data) arbiter for a shared SRAM-like port
// Revision 1.0
// ============================================================================
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_addr_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_data_ok,
    output logic                grant_sel,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       win_data;
    logic       accept;
    logic       complete;

    assign accept   = (state == S_IDLE) && (inst_req || data_req);
    assign complete = (state == S_DATA) && mem_data_ok;

    // Both requesting: fixed priority favours data, round-robin favours whoever lost last time.
    always_comb begin
        win_data = data_req;
        if (inst_req && data_req) begin
            win_data = (RR_EN != 0) ? ~last_grant : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (inst_req || data_req) state_nxt = S_ADDR;
            S_ADDR:  if (mem_addr_ok)          state_nxt = S_DATA;
            S_DATA:  if (mem_data_ok)          state_nxt = S_IDLE;
            default:                           state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == S_ADDR);
        busy    = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_addr_ok <= 1'b0;
            data_addr_ok <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
            grant_sel    <= 1'b0;
            last_grant   <= 1'b1;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
        end else begin
            inst_addr_ok <= accept & ~win_data;
            data_addr_ok <= accept &  win_data;
            inst_data_ok <= complete & ~grant_sel;
            data_data_ok <= complete &  grant_sel;
            if (accept) begin
                grant_sel  <= win_data;
                last_grant <= win_data;
                mem_wr     <= win_data & data_wr;
                mem_addr   <= win_data ? data_addr  : inst_addr;
                mem_wdata  <= win_data ? data_wdata : {DATA_W{1'b0}};
                mem_wstrb  <= win_data ? data_wstrb : {STRB_W{1'b0}};
            end
            if (complete) begin
                if (grant_sel) begin
                    data_rdata <= mem_rdata;
                end else begin
                    inst_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Two-master arbiter that shares the single SoC SRAM-like memory port between the instruction-fetch and data-access requesters of the CPU.
- Owns the grant state and sequences one outstanding transaction at a time: accept, address phase, data phase.
- Drives grant_sel, the select line of the width-parameterised 2:1 muxes that steer addr/wdata onto the shared bus (d0 = inst, d1 = data).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte strobes.
- RR_EN, 0, 0 = fixed priority (data wins), 1 = round-robin between masters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  one-cycle pulse: request accepted.
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid.
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request; held until data_addr_ok.
- data_wr  in  1  1 = store.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_wstrb  in  DATA_W/8  store byte enables.
- data_addr_ok  out  1  one-cycle accept pulse.
- data_data_ok  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  shared-port request.
- mem_wr  out  1  shared-port write.
- mem_addr  out  ADDR_W  shared-port address.
- mem_wdata  out  DATA_W  shared-port write data.
- mem_wstrb  out  DATA_W/8  shared-port strobes; 0 for inst.
- mem_addr_ok  in  1  memory accepted address.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_ok  in  1  memory data phase done.
- grant_sel  out  1  current owner, 0 = inst, 1 = data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, ADDR, DATA. Reset -> IDLE.
- Reset values: all outputs 0, grant_sel 0, mem_* 0, rdata 0, last_grant 1, latched request fields 0.
- IDLE, no req: stay.
- IDLE, any req at edge: pick winner, latch winner's fields (inst: wr = 0, wstrb = 0, wdata = 0), set grant_sel, go ADDR. Winner's addr_ok = 1 for exactly the following cycle.
- Winner selection, RR_EN = 0: data_req beats inst_req.
- Winner selection, RR_EN = 1 and both requesting: the master that is not last_grant wins. last_grant updates to the winner on every accept.
- Single requester: it wins regardless of RR_EN.
- ADDR: mem_req = 1 with latched fields, stable until mem_addr_ok. On mem_addr_ok go DATA and deassert mem_req the next cycle.
- DATA: mem_req = 0. On mem_data_ok capture mem_rdata into owner's rdata, pulse owner's data_ok next cycle, go IDLE.
- Latency: minimum 3 cycles from accept edge to data_ok (mem_addr_ok in 1st ADDR cycle, mem_data_ok in 1st DATA cycle).
- Back-to-back: IDLE may accept a new request in the same cycle data_ok is pulsed.
- mem_data_ok outside DATA: ignored. mem_addr_ok outside ADDR: ignored.
- Non-owner rdata is held unchanged. Loser's request stays pending and is served at the next IDLE.
- Requester req drops without addr_ok: no effect, since sampling happens only in IDLE.
- rst mid-transaction: next cycle IDLE with all outputs at reset values. The transaction is abandoned, no data_ok is issued, and the memory side is reset with the same rst.
- grant_sel holds its value from accept through the end of DATA, and is retained in IDLE.

Test Plan:
- Inst only: inst_req=1 addr=0xBFC00000; mem_addr_ok and mem_data_ok immediate, mem_rdata=0x24080001 -> inst_addr_ok at cycle 1, mem_addr=0xBFC00000 with mem_wr=0, inst_data_ok with rdata 0x24080001 at cycle 3.
- Simultaneous, RR_EN=0: both req -> data granted first (grant_sel=1), inst served next; 3 back-to-back pairs -> data always first.
- Simultaneous, RR_EN=1: both req held continuously -> grants alternate inst, data, inst, data (first inst because last_grant resets to 1).
- Store with stalls: data_wr=1 addr=0x80001000 wdata=0xDEADBEEF wstrb=0xF, mem_addr_ok delayed 4 cycles -> mem_* stable all 4 cycles; mem_data_ok delayed 2 cycles -> data_data_ok 1 cycle after it, inst_data_ok never asserted.
- Reset in DATA: rst asserted during DATA -> next cycle busy=0, mem_req=0, no data_ok pulse; fresh inst_req is then served normally.
- Spurious mem_data_ok while in ADDR -> ignored; completion occurs only on the DATA-state mem_data_ok.
